csel_add_seq: RTL and testbench

- Nibble-serial carry-select adder sequencer for the ALU.
- Adds two WIDTH-bit operands through one shared 4-bit carry-select slice, one nibble per clock, least significant nibble first.
- Each cycle the slice forms the nibble sum for carry-in 0 and for carry-in 1; the registered carry selects between them (4-bit 2:1 select).
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/csel_pkg.sv | 16 +
 rtl/csel_nibble.sv | 30 +++
 rtl/csel_add_seq.sv | 98 +++++++++
 tb/tb_csel_add_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared types and constants for the nibble-serial carry-select adder.
package csel_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int unsigned nnib(input int unsigned width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/csel_nibble.sv
// One 4-bit carry-select slice: two ripple adds (carry-in 0 and 1) and a 2:1 select.
module csel_nibble
    import csel_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             sel,
    output logic [NIB_W-1:0] sum,
    output logic             carry
);

    logic [NIB_W-1:0] s0, s1;
    logic             c0, c1;

    always_comb begin
        s0 = '0;
        s1 = '0;
        c0 = 1'b0;
        c1 = 1'b1;
        for (int i = 0; i < NIB_W; i++) begin
            s0[i] = a[i] ^ b[i] ^ c0;
            c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            s1[i] = a[i] ^ b[i] ^ c1;
            c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
        sum   = sel ? s1 : s0;
        carry = sel ? c1 : c0;
    end

endmodule

// File: rtl/csel_add_seq.sv
// Nibble-serial adder: one shared carry-select slice, LSB nibble first,
// valid/ready handshake on operands and result.
module csel_add_seq
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NNIB = nnib(WIDTH);
    localparam int unsigned CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_carry;
    logic [WIDTH-1:0] sum_shift;

    csel_nibble u_nibble (
        .a     (a_q[NIB_W-1:0]),
        .b     (b_q[NIB_W-1:0]),
        .sel   (carry_q),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    // New nibble enters at the top; after NNIB steps nibble 0 sits at the bottom.
    assign sum_shift = (sum >> NIB_W) | (WIDTH'(nib_sum) << (WIDTH - NIB_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        cnt_q    <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> NIB_W;
                    b_q     <= b_q >> NIB_W;
                    carry_q <= nib_carry;
                    sum     <= sum_shift;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NNIB - 1)) begin
                        cout    <= nib_carry;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result is presented one cycle after the last nibble lands.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csel_add_seq.sv
// Directed and random checks of csel_add_seq against a transaction-level adder model.
module tb_csel_add_seq;

    localparam int NNIB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid, out_ready;
    logic [15:0] sum;
    logic        cout, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          acc;
    } txn_t;

    txn_t q[$];
    logic prev_ov = 1'b0;

    csel_add_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction tracking: operands enter on accept, leave on result handshake.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (in_valid && in_ready) q.push_back('{a, b, cin, cyc});
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    always @(posedge rst) q.delete();

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        logic [16:0] exp;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            check(!(in_ready && out_valid), "ready_valid_excl", {in_ready, out_valid}, 0);
            check(busy == (q.size() != 0), "busy", busy, q.size() != 0);
            check(in_ready == (q.size() == 0), "in_ready", in_ready, q.size() == 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check(0, "spurious_out_valid", out_valid, 0);
                end else begin
                    exp = {1'b0, q[0].a} + {1'b0, q[0].b} + {16'b0, q[0].cin};
                    check(sum === exp[15:0], "model_sum", sum, exp[15:0]);
                    check(cout === exp[16], "model_cout", cout, exp[16]);
                    if (!prev_ov)
                        check(cyc - q[0].acc == NNIB + 1, "latency", cyc - q[0].acc, NNIB + 1);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb,
                                  input logic tc, input string nm);
        int n;
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check(0, {nm, "_accept_timeout"}, in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        if (!out_valid) check(0, {nm, "_result_timeout"}, out_valid, 1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                           input logic [15:0] es, input logic ec, input string nm);
        start_and_wait(ta, tb, tc, nm);
        check(sum === es, {nm, "_sum"}, sum, es);
        check(cout === ec, {nm, "_cout"}, cout, ec);
        release_result();
    endtask

    initial begin
        logic [16:0] r;
        logic [15:0] ra, rb;
        logic        rc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        check(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
        check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
        check(busy === 1'b0, "rst_busy", busy, 0);
        check(sum === 16'h0, "rst_sum", sum, 0);
        check(cout === 1'b0, "rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "d1");
        run_txn(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "d2");
        run_txn(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, "d3");
        run_txn(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "d4");

        // Backpressure: hold result, try to sneak in an operand.
        start_and_wait(16'h1234, 16'h4321, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
            @(negedge clk);
            check(sum === 16'h5555, "hold_sum", sum, 16'h5555);
            check(cout === 1'b0, "hold_cout", cout, 0);
            check(in_ready === 1'b0, "hold_in_ready", in_ready, 0);
            check(out_valid === 1'b1, "hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        release_result();
        check(in_ready === 1'b1, "rel_in_ready", in_ready, 1);
        check(out_valid === 1'b0, "rel_out_valid", out_valid, 0);
        check(sum === 16'h5555, "rel_sum_kept", sum, 16'h5555);

        // Asynchronous reset at counter = 2 (two nibbles of 0x2345 shifted in).
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check(sum === 16'h4500, "partial_sum", sum, 16'h4500);
        check(busy === 1'b1, "partial_busy", busy, 1);
        rst = 1'b1;
        #1;
        check(sum === 16'h0, "async_rst_sum", sum, 0);
        check(busy === 1'b0, "async_rst_busy", busy, 0);
        check(in_ready === 1'b1, "async_rst_in_ready", in_ready, 1);
        check(out_valid === 1'b0, "async_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "post_rst");

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            r = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            run_txn(ra, rb, rc, r[15:0], r[16], "rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
